// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM state type and helpers for the cache controller
package cache_pkg;
    localparam int ADDR_W     = 32;
    localparam int OFFSET_W   = 2;
    localparam int IDX_W      = 5;
    localparam int DATA_W     = 32;
    localparam int TAG_W      = ADDR_W - IDX_W - OFFSET_W;
    localparam int LINES      = 1 << IDX_W;
    localparam int AVL_ADDR_W = 26;
    localparam int AVL_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - CPU request and Avalon-MM bundles with master/slave modports
interface cache_cpu_if;
    import cache_pkg::*;
    logic [ADDR_W-1:0] cpu2cache_addr;
    logic [DATA_W-1:0] cpu2cache_data_in;
    logic              cpu2cache_rw;
    logic              cpu2cache_valid;
    logic [DATA_W-1:0] cache2cpu_data_out;
    logic              cache2cpu_ready;

    modport master (output cpu2cache_addr, cpu2cache_data_in, cpu2cache_rw, cpu2cache_valid,
                    input  cache2cpu_data_out, cache2cpu_ready);
    modport slave  (input  cpu2cache_addr, cpu2cache_data_in, cpu2cache_rw, cpu2cache_valid,
                    output cache2cpu_data_out, cache2cpu_ready);
endinterface

interface cache_avl_if;
    import cache_pkg::*;
    logic                  avl_wait;
    logic                  avl_readdatavalid;
    logic [AVL_DATA_W-1:0] avl_readdata;
    logic [AVL_ADDR_W-1:0] avl_address;
    logic [AVL_DATA_W-1:0] avl_writedata;
    logic                  avl_read;
    logic                  avl_write;

    modport master (input  avl_wait, avl_readdatavalid, avl_readdata,
                    output avl_address, avl_writedata, avl_read, avl_write);
    modport slave  (output avl_wait, avl_readdatavalid, avl_readdata,
                    input  avl_address, avl_writedata, avl_read, avl_write);
endinterface

// File: rtl/cache_ctrl_avl_mem_bridge.sv
// rtl/cache_ctrl_avl_mem_bridge.sv - single-word Avalon read/write sequencer with done pulse
module avl_mem_bridge
    import cache_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    cache_avl_if.master       avl
);
    localparam logic [1:0] B_IDLE    = 2'd0;
    localparam logic [1:0] B_RD_CMD  = 2'd1;
    localparam logic [1:0] B_RD_WAIT = 2'd2;
    localparam logic [1:0] B_WR_CMD  = 2'd3;

    logic [1:0]            bst_q, bst_d;
    logic [AVL_ADDR_W-1:0] addr_q, addr_d;
    logic [AVL_DATA_W-1:0] wdata_q, wdata_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  done_q, done_d;

    logic unused_bits;
    assign unused_bits = &{1'b0, mem_addr[ADDR_W-1:AVL_ADDR_W+2], mem_addr[1:0],
                           avl.avl_readdata[AVL_DATA_W-1:DATA_W]};

    always_comb begin
        bst_d   = bst_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        read_d  = read_q;
        write_d = write_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        case (bst_q)
            B_IDLE: begin
                // The requester keeps its request level for one cycle after done; ignore it then.
                if (!done_q) begin
                    if (rd_req) begin
                        read_d = 1'b1;
                        addr_d = mem_addr[AVL_ADDR_W+1:2];
                        bst_d  = B_RD_CMD;
                    end else if (wr_req) begin
                        write_d = 1'b1;
                        addr_d  = mem_addr[AVL_ADDR_W+1:2];
                        wdata_d = {{(AVL_DATA_W-DATA_W){1'b0}}, wdata};
                        bst_d   = B_WR_CMD;
                    end
                end
            end
            B_RD_CMD: begin
                if (!avl.avl_wait) begin
                    read_d = 1'b0;
                    bst_d  = B_RD_WAIT;
                end
            end
            B_RD_WAIT: begin
                if (avl.avl_readdatavalid) begin
                    rdata_d = avl.avl_readdata[DATA_W-1:0];
                    done_d  = 1'b1;
                    bst_d   = B_IDLE;
                end
            end
            B_WR_CMD: begin
                if (!avl.avl_wait) begin
                    write_d = 1'b0;
                    done_d  = 1'b1;
                    bst_d   = B_IDLE;
                end
            end
            default: bst_d = B_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            bst_q   <= B_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            bst_q   <= bst_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            read_q  <= read_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    assign avl.avl_address   = addr_q;
    assign avl.avl_writedata = wdata_q;
    assign avl.avl_read      = read_q;
    assign avl.avl_write     = write_q;
    assign rdata             = rdata_q;
    assign done              = done_q;
endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-back write-allocate cache controller
// Optional hit/miss counters enabled by defining CACHE_STATS_EN.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic        iCLK,
    input  logic        iRST,
    cache_cpu_if.slave  cpu,
    cache_avl_if.master avl
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              phase_q, phase_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [TAG_W-1:0]  rd_tag_q, rd_tag_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    logic              br_rd, br_wr, br_done;
    logic [ADDR_W-1:0] br_addr;
    logic [DATA_W-1:0] br_wdata, br_rdata;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;

    assign idx = addr_q[OFFSET_W+IDX_W-1:OFFSET_W];
    assign tag = addr_q[ADDR_W-1:OFFSET_W+IDX_W];
    assign hit = valid_q[idx] && (rd_tag_q == tag);

    // Registered array read, so COMPARE spends its first cycle fetching the line.
    assign rd_tag_d  = tag_mem[idx];
    assign rd_data_d = data_mem[idx];

`ifdef CACHE_STATS_EN
    logic        first_q, first_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        data_out_d = data_out_q;
        phase_d    = phase_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        mem_we     = 1'b0;
        mem_wdata  = wdata_q;
        br_rd      = 1'b0;
        br_wr      = 1'b0;
        br_addr    = addr_q;
        br_wdata   = rd_data_q;
`ifdef CACHE_STATS_EN
        first_d    = first_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu.cpu2cache_valid) begin
                    addr_d  = cpu.cpu2cache_addr;
                    wdata_d = cpu.cpu2cache_data_in;
                    rw_d    = cpu.cpu2cache_rw;
                    phase_d = 1'b0;
                    state_d = COMPARE;
`ifdef CACHE_STATS_EN
                    first_d = 1'b1;
`endif
                end
            end
            COMPARE: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
`ifdef CACHE_STATS_EN
                    if (first_q) begin
                        first_d = 1'b0;
                        if (hit) hit_cnt_d  = sat_inc32(hit_cnt_q);
                        else     miss_cnt_d = sat_inc32(miss_cnt_q);
                    end
`endif
                    if (hit) begin
                        if (rw_q) begin
                            mem_we       = 1'b1;
                            dirty_d[idx] = 1'b1;
                        end else begin
                            data_out_d = rd_data_q;
                        end
                        state_d = IDLE;
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                br_wr   = 1'b1;
                br_addr = {rd_tag_q, idx, {OFFSET_W{1'b0}}};
                if (br_done) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                br_rd = 1'b1;
                if (br_done) begin
                    mem_we       = 1'b1;
                    mem_wdata    = br_rdata;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    phase_d      = 1'b0;
                    state_d      = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            data_out_q <= '0;
            phase_q    <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            data_out_q <= data_out_d;
            phase_q    <= phase_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (mem_we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_wdata;
        end
        rd_tag_q  <= rd_tag_d;
        rd_data_q <= rd_data_d;
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            first_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            first_q    <= first_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    avl_mem_bridge u_bridge (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .rd_req   (br_rd),
        .wr_req   (br_wr),
        .mem_addr (br_addr),
        .wdata    (br_wdata),
        .rdata    (br_rdata),
        .done     (br_done),
        .avl      (avl)
    );

    assign cpu.cache2cpu_data_out = data_out_q;
    assign cpu.cache2cpu_ready    = (state_q == IDLE);
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed self-checking bench for cache_ctrl with an Avalon responder
module tb_cache_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_cpu_if cpu();
    cache_avl_if avl();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    cache_ctrl dut (
        .iCLK (clk),
        .iRST (rst),
        .cpu  (cpu),
        .avl  (avl)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Avalon slave model
    int           stall = 0;
    logic [31:0]  resp  = 32'd0;
    int           rd_cnt = 0, wr_cnt = 0, stab_err = 0, both_err = 0, stall_seen = 0;
    logic [25:0]  last_rd_addr = '0, last_wr_addr = '0;
    logic [127:0] last_wd = '0;

    initial begin
        int          wait_left;
        logic        in_cmd;
        logic        rd_pending;
        logic [25:0] cmd_addr;
        logic [127:0] cmd_wd;
        wait_left = 0; in_cmd = 1'b0; rd_pending = 1'b0; cmd_addr = '0; cmd_wd = '0;
        avl.avl_wait = 1'b0;
        avl.avl_readdatavalid = 1'b0;
        avl.avl_readdata = '0;
        forever begin
            @(posedge clk);
            #2;
            avl.avl_readdatavalid = 1'b0;
            if (rd_pending) begin
                avl.avl_readdatavalid = 1'b1;
                avl.avl_readdata = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hC3C3C3C3, resp};
                rd_pending = 1'b0;
            end
            if (avl.avl_read && avl.avl_write) both_err++;
            if (avl.avl_read || avl.avl_write) begin
                if (!in_cmd) begin
                    in_cmd = 1'b1;
                    cmd_addr = avl.avl_address;
                    cmd_wd = avl.avl_writedata;
                    wait_left = stall;
                end else if (avl.avl_address !== cmd_addr ||
                             (avl.avl_write && avl.avl_writedata !== cmd_wd)) begin
                    stab_err++;
                end
                if (wait_left > 0) begin
                    avl.avl_wait = 1'b1;
                    wait_left--;
                    stall_seen++;
                end else begin
                    avl.avl_wait = 1'b0;
                    in_cmd = 1'b0;
                    if (avl.avl_read) begin
                        rd_cnt++;
                        last_rd_addr = avl.avl_address;
                        rd_pending = 1'b1;
                    end else begin
                        wr_cnt++;
                        last_wr_addr = avl.avl_address;
                        last_wd = avl.avl_writedata;
                    end
                end
            end else begin
                avl.avl_wait = 1'b0;
                in_cmd = 1'b0;
            end
        end
    end

    task automatic cpu_req(input logic rw, input logic [31:0] a, input logic [31:0] d, output int lat);
        @(negedge clk);
        cpu.cpu2cache_addr    = a;
        cpu.cpu2cache_data_in = d;
        cpu.cpu2cache_rw      = rw;
        cpu.cpu2cache_valid   = 1'b1;
        @(posedge clk);
        #1;
        cpu.cpu2cache_valid = 1'b0;
        lat = 0;
        while (!cpu.cache2cpu_ready && lat < 500) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!cpu.cache2cpu_ready) chk("req_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat;
        int rd0, wr0, st0;
        cpu.cpu2cache_addr = '0;
        cpu.cpu2cache_data_in = '0;
        cpu.cpu2cache_rw = 1'b0;
        cpu.cpu2cache_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", cpu.cache2cpu_ready, 1);
        chk("rst_dout", cpu.cache2cpu_data_out, 0);
        chk("rst_read", avl.avl_read, 0);
        chk("rst_write", avl.avl_write, 0);
        chk("rst_addr", avl.avl_address, 0);
        chk("rst_wdata", avl.avl_writedata[63:0], 0);

        // write miss on an empty line: fill only, no eviction
        resp = 32'd234;
        cpu_req(1'b1, 32'd4, 32'd5, lat);
        chk("w4_rd_cnt", rd_cnt, 1);
        chk("w4_rd_addr", last_rd_addr, 1);
        chk("w4_wr_cnt", wr_cnt, 0);

        resp = 32'd77;
        cpu_req(1'b1, 32'd8, 32'd10, lat);
        chk("w8_rd_addr", last_rd_addr, 2);
        rd0 = rd_cnt; wr0 = wr_cnt;
        cpu_req(1'b0, 32'd4, 32'd0, lat);
        chk("r4_data", cpu.cache2cpu_data_out, 5);
        chk("r4_lat", lat, 2);
        cpu_req(1'b0, 32'd8, 32'd0, lat);
        chk("r8_data", cpu.cache2cpu_data_out, 10);
        chk("r8_lat", lat, 2);
        chk("hits_no_rd", rd_cnt, rd0);
        chk("hits_no_wr", wr_cnt, wr0);

        // write hit leaves data_out alone
        cpu_req(1'b1, 32'd4, 32'd15, lat);
        chk("w4hit_lat", lat, 2);
        chk("w4hit_dout_hold", cpu.cache2cpu_data_out, 10);
        cpu_req(1'b0, 32'd4, 32'd0, lat);
        chk("r4_15", cpu.cache2cpu_data_out, 15);
        chk("w4hit_no_rd", rd_cnt, rd0);
        chk("w4hit_no_wr", wr_cnt, wr0);

        // conflict miss on dirty line: evict 15 to word 1, fill from word 33
        resp = 32'd43;
        cpu_req(1'b1, 32'd132, 32'd20, lat);
        chk("w132_wr_cnt", wr_cnt, wr0 + 1);
        chk("w132_wr_addr", last_wr_addr, 1);
        chk("w132_wd_lo", last_wd[31:0], 15);
        chk("w132_wd_hi", last_wd[127:64], 0);
        chk("w132_wd_mid", last_wd[63:32], 0);
        chk("w132_rd_addr", last_rd_addr, 33);
        chk("w132_rd_cnt", rd_cnt, rd0 + 1);
        cpu_req(1'b0, 32'd132, 32'd0, lat);
        chk("r132_data", cpu.cache2cpu_data_out, 20);
        chk("r132_lat", lat, 2);

        resp = 32'd15;
        cpu_req(1'b0, 32'd4, 32'd0, lat);
        chk("r4b_wr_addr", last_wr_addr, 33);
        chk("r4b_wd", last_wd[31:0], 20);
        chk("r4b_rd_addr", last_rd_addr, 1);
        chk("r4b_data", cpu.cache2cpu_data_out, 15);

        // stalled writeback (10 -> word 2) and stalled fill (word 34)
        stall = 3; resp = 32'h77;
        st0 = stall_seen; wr0 = wr_cnt; rd0 = rd_cnt;
        cpu_req(1'b1, 32'd136, 32'h55, lat);
        stall = 0;
        chk("stall_cycles", stall_seen - st0, 6);
        chk("stall_stable", stab_err, 0);
        chk("stall_wr_addr", last_wr_addr, 2);
        chk("stall_wd", last_wd[31:0], 10);
        chk("stall_rd_addr", last_rd_addr, 34);
        chk("stall_wr_cnt", wr_cnt, wr0 + 1);
        cpu_req(1'b0, 32'd136, 32'd0, lat);
        chk("r136_data", cpu.cache2cpu_data_out, 32'h55);

        // reset while ALLOCATE holds a stalled read
        stall = 20;
        @(negedge clk);
        cpu.cpu2cache_addr = 32'd200;
        cpu.cpu2cache_rw = 1'b0;
        cpu.cpu2cache_valid = 1'b1;
        @(posedge clk);
        #1;
        cpu.cpu2cache_valid = 1'b0;
        chk("acc_ready_low", cpu.cache2cpu_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("alloc_read", avl.avl_read, 1);
        chk("alloc_addr", avl.avl_address, 50);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", cpu.cache2cpu_ready, 1);
        chk("mid_rst_read", avl.avl_read, 0);
        chk("mid_rst_addr", avl.avl_address, 0);
        chk("mid_rst_dout", cpu.cache2cpu_data_out, 0);
        @(negedge clk);
        rst = 1'b0;
        stall = 0;
        repeat (2) @(posedge clk);

        // dirty 0x55 at 136 was discarded: plain refill, no eviction
        resp = 32'd99;
        wr0 = wr_cnt; rd0 = rd_cnt;
        cpu_req(1'b0, 32'd136, 32'd0, lat);
        chk("post_rst_no_wb", wr_cnt, wr0);
        chk("post_rst_rd", rd_cnt, rd0 + 1);
        chk("post_rst_data", cpu.cache2cpu_data_out, 99);
        chk("never_both", both_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
